// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state enum, the default reset PC and the PC increment.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } if_state_e;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC      = 32'd4;

endpackage

// File: rtl/if_fetch_perf.sv
// if_fetch_perf: wrapping fetch/discard event counters for the fetch stage.
// Ports: clk, rst (async, active-high), fetch_inc, kill_inc in;
//   perf_fetch_cnt, perf_kill_cnt out.
module if_fetch_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        kill_inc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_kill_cnt
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (fetch_inc) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (kill_inc)  kill_cnt_d  = kill_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_kill_cnt  = kill_cnt_q;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC owner and single-outstanding fetch FSM feeding the IF/ID register.
// Ports: clk, rst (async, active-high); imem_req/addr out, imem_gnt/rvalid/rdata in;
//   redirect_valid/redirect_pc from EX; id_ready in; if_valid/if_pc/if_inst/if_pc4 out.
// Define IF_FETCH_PERF_EN to add perf_fetch_cnt and perf_kill_cnt outputs.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_kill_cnt
`endif
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        valid_q, valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic [31:0] redir_tgt;
    logic        capture;
    logic        discard;

    assign redir_tgt = redirect_pc & ~32'h3;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        valid_d = valid_q;
        capture = 1'b0;
        discard = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                    // Granted fetch is for the stale PC; drop its response.
                    if (redirect_valid) kill_d = 1'b1;
                end else if (redirect_valid) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                    if (redirect_valid || kill_q) begin
                        discard = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || id_ready) begin
                    state_d = REQ;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            valid_d = 1'b1;
            pc_d    = pc_q + PC_INC;
        end
        if (discard) kill_d = 1'b0;
        if (redirect_valid) begin
            pc_d    = redir_tgt;
            valid_d = 1'b0;
        end
    end

    always_comb begin
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;
        if_pc4_d  = if_pc4_q;
        if (capture) begin
            if_pc_d   = pc_q;
            if_inst_d = imem_rdata;
            if_pc4_d  = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            valid_q   <= 1'b0;
            if_pc_q   <= 32'd0;
            if_inst_q <= 32'd0;
            if_pc4_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            valid_q   <= valid_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
            if_pc4_q  <= if_pc4_d;
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;
    assign if_valid  = valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;
    assign if_pc4    = if_pc4_q;

`ifdef IF_FETCH_PERF_EN
    if_fetch_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .fetch_inc      (capture),
        .kill_inc       (discard),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_kill_cnt  (perf_kill_cnt)
    );
`endif

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage at the front of the five-stage pipeline. It owns the program counter, issues single-outstanding fetches over a req/gnt/rvalid instruction-memory interface, and presents the fetched word with its PC and PC+4 toward the IF/ID register under a valid/ready handshake. Branch or jump redirects from EX flush in-flight work and restart fetching at the target.

## Interface

- RESET_PC, 32'h0000_0000, first fetch address after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request; high only in state REQ.
- imem_addr  out  32  fetch address, equals the PC register; bits [1:0] always 0.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; never in the same cycle as its own gnt.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  one-cycle redirect pulse from EX.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- id_ready  in  1  downstream accepts the presented instruction.
- if_valid  out  1  if_pc/if_inst/if_pc4 hold a live instruction.
- if_pc  out  32  PC of the presented instruction.
- if_inst  out  32  presented instruction word.
- if_pc4  out  32  if_pc + 4, modulo 2^32.

## Operation

- States: IDLE, REQ, WAIT, HOLD. Reset state is IDLE. The PC register resets to RESET_PC, and the kill flag resets to 0.
- IDLE: imem_req=0. Next state is REQ unconditionally.
- REQ: imem_req=1 and imem_addr=pc. Both are held stable until imem_gnt. On gnt, the next state is WAIT.
- WAIT: waits for imem_rvalid. If rvalid arrives and kill=0, capture imem_rdata into if_inst, pc into if_pc and pc+4 into if_pc4, set if_valid=1, advance pc by 4, and go to HOLD. If rvalid arrives and kill=1, discard the data, clear kill, and go to REQ.
- HOLD: if_valid=1 and the outputs stay stable. If id_ready=1, clear if_valid and go to REQ.
- Redirect has the highest priority in every state. It always loads pc with {redirect_pc[31:2],2'b00} and clears if_valid in the same edge.
  - IDLE: go to REQ.
  - REQ without gnt: withdraw the request and go to IDLE. imem_req is low for one cycle, then the new address is requested.
  - REQ with gnt in the same cycle: go to WAIT with kill=1.
  - WAIT without rvalid: set kill=1 and stay in WAIT.
  - WAIT with rvalid in the same cycle: discard the data and go to REQ with kill=0.
  - HOLD: the presented instruction is dropped and the next state is REQ. A simultaneous id_ready is ignored.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC+4 gives 0.
- Exactly one request is outstanding at any time.

## Timing

- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, if_pc4=0.
- Asserting rst mid-operation returns the block to IDLE immediately. Any outstanding response is then ignored, because the memory is reset with the core.
- Minimum per-instruction cycle, with gnt immediate, rvalid one cycle later and id_ready high: REQ(1) + WAIT(1) + HOLD(1) = 3 cycles.
- The first imem_req rises in the second cycle after rst deasserts.
- if_valid rises on the edge after rvalid. It falls on the edge where id_ready is sampled high in HOLD, or on any redirect edge.
- After a redirect, the first request at the new PC is issued:
  - 1 cycle later from HOLD, WAIT+rvalid or IDLE.
  - 2 cycles later from REQ without gnt.
  - after the killed response from WAIT without rvalid.

## Configuration

- IF_FETCH_PERF_EN defined: adds the outputs perf_fetch_cnt[31:0] and perf_kill_cnt[31:0], both reset to 0 and both wrapping.
  - perf_fetch_cnt increments on every capture into HOLD.
  - perf_kill_cnt increments on every discarded response, whether the discard was flagged by kill or happened on a same-cycle redirect.
- Not defined: those ports and counters are absent, and fetch behaviour is otherwise identical.

## Structure

- Shared package if_pkg holds:
  - the state enum (IDLE, REQ, WAIT, HOLD);
  - the RESET_PC default;
  - the PC increment constant 4.
- One sub-module, if_fetch_perf, holds the two counters. It is instantiated only under IF_FETCH_PERF_EN.
- The PC register, FSM and output registers stay in if_fetch.

## Test plan

- Reset, then gnt immediate, rvalid next cycle with data 32'h0000_0013, id_ready=1:
  - imem_addr runs 0, 4, 8;
  - if_valid pulses every 3 cycles;
  - if_pc=0 with if_pc4=4, then if_pc=4 with if_pc4=8.
- id_ready held low for 5 cycles in HOLD with if_pc=8 and if_inst=32'h00A0_0093: the outputs stay stable and imem_req stays 0 until id_ready rises.
- Redirect to 32'h0000_0103 during WAIT, with rvalid 2 cycles later:
  - that response is discarded and if_valid stays 0;
  - the next request uses address 32'h0000_0100;
  - perf_kill_cnt=1 when the macro is defined.
- Redirect in REQ with gnt held low:
  - imem_req drops for exactly one cycle;
  - it then reasserts with imem_addr at the redirect target.
- Redirect in the same cycle as rvalid, and separately the same cycle as id_ready in HOLD: the data is dropped, if_valid=0, and the next fetch is at the target.
- RESET_PC=32'hFFFF_FFFC: the first instruction shows if_pc4=0, and the second fetch address is 0.
